// File: rtl/m_down_counter_timer_pkg.sv
// Shared timer definitions: FSM state encoding and default counter width.
// Pure declarations, no logic and no latency.
// No flow control; the timer blocks and the up-counter import this package.
package m_down_counter_timer_pkg;

    // Default count/period width for timers that do not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Timer FSM encoding. 2'd3 is intentionally unused; a timer that lands
    // there (upset, bad reset release) recovers to S_IDLE on the next edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/m_down_counter_timer.sv
// Loadable down-counter with registered terminal-count pulse and optional auto-reload.
// Latency: start at edge k enters RUN at k; w_tc is high for the cycle after edge k+N.
// No backpressure: control inputs are sampled every edge, priority load > stop > start.
module m_down_counter_timer
    import m_down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             w_clock,
    input  logic             w_reset,
    input  logic             w_load,
    input  logic [WIDTH-1:0] w_load_value,
    input  logic             w_start,
    input  logic             w_stop,
    input  logic             w_auto_reload,
    output logic [WIDTH-1:0] w_count,
    output logic             w_tc,
    output logic             w_busy,
    output logic [1:0]       w_state
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             tc;

    // Decode helpers kept outside the sequential block for readability.
    logic             load_nonzero;
    logic             count_nonzero;
    logic             reload_armed;
    logic             start_only;

    assign load_nonzero  = (w_load_value != '0);
    assign count_nonzero = (count != '0);
    // Auto-reload only re-arms when there is a non-zero period to reload;
    // a zero reload would otherwise leave RUN stuck at zero.
    assign reload_armed  = w_auto_reload && (reload != '0);
    // Start counts only when neither load nor stop claims the edge.
    assign start_only    = w_start && !w_stop && !w_load;

    // FSM, count, reload and tc updated together so every output comes from a flop.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            state  <= S_IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_load) begin
                        count  <= w_load_value;
                        reload <= w_load_value;
                    end else if (start_only && count_nonzero) begin
                        // Starting at zero would terminate instantly; stay idle
                        // and do not pulse.
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_load) begin
                        // A reload mid-run replaces the period without a pulse.
                        count  <= w_load_value;
                        reload <= w_load_value;
                        state  <= load_nonzero ? S_RUN : S_IDLE;
                    end else if (w_stop) begin
                        state <= S_PAUSE;
                    end else if (count > ONE) begin
                        count <= count - ONE;
                    end else if (count == ONE) begin
                        tc <= 1'b1;
                        if (reload_armed) begin
                            // Skip the zero value so the period is exactly N.
                            count <= reload;
                        end else begin
                            count <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        // Zero in RUN is unreachable; fall back to idle safely.
                        state <= S_IDLE;
                    end
                end

                S_PAUSE: begin
                    if (w_load) begin
                        count  <= w_load_value;
                        reload <= w_load_value;
                        state  <= S_IDLE;
                    end else if (start_only) begin
                        // Resume edge only changes state; decrement follows next edge.
                        state <= S_RUN;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_count = count;
    assign w_tc    = tc;
    assign w_busy  = (state == S_RUN);
    assign w_state = state;

endmodule

// File: tb/tb_m_down_counter_timer.sv
module tb_m_down_counter_timer;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic       clk;
    logic       rst;

    logic       a_load, a_start, a_stop, a_ar;
    logic [7:0] a_value;
    logic [7:0] a_count;
    logic       a_tc, a_busy;
    logic [1:0] a_state;

    logic       b_load, b_start, b_stop, b_ar;
    logic [1:0] b_value;
    logic [1:0] b_count;
    logic       b_tc, b_busy;
    logic [1:0] b_state;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] cnt;
        logic       tc;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    m_down_counter_timer #(.WIDTH(8)) u_dut_a (
        .w_clock       (clk),
        .w_reset       (rst),
        .w_load        (a_load),
        .w_load_value  (a_value),
        .w_start       (a_start),
        .w_stop        (a_stop),
        .w_auto_reload (a_ar),
        .w_count       (a_count),
        .w_tc          (a_tc),
        .w_busy        (a_busy),
        .w_state       (a_state)
    );

    m_down_counter_timer #(.WIDTH(2)) u_dut_b (
        .w_clock       (clk),
        .w_reset       (rst),
        .w_load        (b_load),
        .w_load_value  (b_value),
        .w_start       (b_start),
        .w_stop        (b_stop),
        .w_auto_reload (b_ar),
        .w_count       (b_count),
        .w_tc          (b_tc),
        .w_busy        (b_busy),
        .w_state       (b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input string what,
                       input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp_v);
    endtask

    task automatic push_exp(input string tag, input int dut,
                            input logic [7:0] cnt, input logic tc, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.dut = dut; e.cnt = cnt; e.tc = tc; e.st = st;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t       e;
        logic [7:0] oc;
        logic       otc, obusy;
        logic [1:0] ost;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard: observed empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        if (e.dut == 0) begin
            oc = a_count; otc = a_tc; obusy = a_busy; ost = a_state;
        end else begin
            oc = {6'b0, b_count}; otc = b_tc; obusy = b_busy; ost = b_state;
        end
        chk(e.tag, "count", oc, e.cnt);
        chk(e.tag, "tc", {7'b0, otc}, {7'b0, e.tc});
        chk(e.tag, "state", {6'b0, ost}, {6'b0, e.st});
        chk(e.tag, "busy", {7'b0, obusy}, {7'b0, (e.st == RUN)});
    endtask

    // Drive DUT A inputs for one edge, then compare against the expectation.
    task automatic a_step(input string tag, input logic l, input logic [7:0] v,
                          input logic s, input logic p, input logic ar,
                          input logic [7:0] ec, input logic etc, input logic [1:0] est);
        a_load = l; a_value = v; a_start = s; a_stop = p; a_ar = ar;
        push_exp(tag, 0, ec, etc, est);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic b_step(input string tag, input logic l, input logic [1:0] v,
                          input logic s, input logic p, input logic ar,
                          input logic [7:0] ec, input logic etc, input logic [1:0] est);
        b_load = l; b_value = v; b_start = s; b_stop = p; b_ar = ar;
        push_exp(tag, 1, ec, etc, est);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        int tc_seen;
        rst = 1'b1;
        a_load = 0; a_value = 0; a_start = 0; a_stop = 0; a_ar = 0;
        b_load = 0; b_value = 0; b_start = 0; b_stop = 0; b_ar = 0;

        // Reset state of both instances.
        #1;
        push_exp("reset_a", 0, 8'd0, 1'b0, IDLE);
        compare_front();
        push_exp("reset_b", 1, 8'd0, 1'b0, IDLE);
        compare_front();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-run takes effect without a clock edge.
        a_step("rr_load",  1, 8'd5, 0, 0, 0, 8'd5, 0, IDLE);
        a_step("rr_start", 0, 8'd0, 1, 0, 0, 8'd5, 0, RUN);
        a_step("rr_dec1",  0, 8'd0, 0, 0, 0, 8'd4, 0, RUN);
        a_step("rr_dec2",  0, 8'd0, 0, 0, 0, 8'd3, 0, RUN);
        #2;
        rst = 1'b1;
        #1;
        push_exp("rr_async", 0, 8'd0, 1'b0, IDLE);
        compare_front();
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Reload register was cleared too: start from zero stays idle.
        a_step("rr_start0", 0, 8'd0, 1, 0, 0, 8'd0, 0, IDLE);

        // One-shot period 3.
        a_step("os_load",  1, 8'd3, 0, 0, 0, 8'd3, 0, IDLE);
        a_step("os_start", 0, 8'd0, 1, 0, 0, 8'd3, 0, RUN);
        a_step("os_2",     0, 8'd0, 0, 0, 0, 8'd2, 0, RUN);
        a_step("os_1",     0, 8'd0, 0, 0, 0, 8'd1, 0, RUN);
        a_step("os_tc",    0, 8'd0, 0, 0, 0, 8'd0, 1, IDLE);
        a_step("os_hold",  0, 8'd0, 0, 0, 0, 8'd0, 0, IDLE);
        a_step("os_zero_start", 0, 8'd0, 1, 0, 0, 8'd0, 0, IDLE);

        // Auto-reload period 4 for 20 cycles.
        a_step("ar_load",  1, 8'd4, 0, 0, 1, 8'd4, 0, IDLE);
        a_step("ar_start", 0, 8'd0, 1, 0, 1, 8'd4, 0, RUN);
        tc_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            a_step($sformatf("ar_%0d", i), 0, 8'd0, 0, 0, 1,
                   (i % 4 == 0) ? 8'd4 : 8'(4 - (i % 4)), (i % 4 == 0), RUN);
            if (a_tc) tc_seen++;
        end
        chk("ar", "tc_pulses", 8'(tc_seen), 8'd5);
        // Dropping auto-reload lets the current period run out one-shot.
        a_step("ar_off3", 0, 8'd0, 0, 0, 0, 8'd3, 0, RUN);
        a_step("ar_off2", 0, 8'd0, 0, 0, 0, 8'd2, 0, RUN);
        a_step("ar_off1", 0, 8'd0, 0, 0, 0, 8'd1, 0, RUN);
        a_step("ar_off0", 0, 8'd0, 0, 0, 0, 8'd0, 1, IDLE);

        // Pause and resume.
        a_step("pr_load",  1, 8'd6, 0, 0, 0, 8'd6, 0, IDLE);
        a_step("pr_start", 0, 8'd0, 1, 0, 0, 8'd6, 0, RUN);
        a_step("pr_5",     0, 8'd0, 0, 0, 0, 8'd5, 0, RUN);
        a_step("pr_4",     0, 8'd0, 0, 0, 0, 8'd4, 0, RUN);
        a_step("pr_stop",  0, 8'd0, 0, 1, 0, 8'd4, 0, PAUSE);
        a_step("pr_hold1", 0, 8'd0, 0, 1, 0, 8'd4, 0, PAUSE);
        a_step("pr_hold2", 0, 8'd0, 0, 0, 0, 8'd4, 0, PAUSE);
        a_step("pr_hold3", 0, 8'd0, 0, 0, 0, 8'd4, 0, PAUSE);
        a_step("pr_resume",0, 8'd0, 1, 0, 0, 8'd4, 0, RUN);
        a_step("pr_3",     0, 8'd0, 0, 0, 0, 8'd3, 0, RUN);
        a_step("pr_2",     0, 8'd0, 0, 0, 0, 8'd2, 0, RUN);
        a_step("pr_1",     0, 8'd0, 0, 0, 0, 8'd1, 0, RUN);
        a_step("pr_tc",    0, 8'd0, 0, 0, 0, 8'd0, 1, IDLE);
        // Load while paused goes back to idle with the new period.
        a_step("pl_load",  1, 8'd6, 0, 0, 0, 8'd6, 0, IDLE);
        a_step("pl_start", 0, 8'd0, 1, 0, 0, 8'd6, 0, RUN);
        a_step("pl_stop",  0, 8'd0, 0, 1, 0, 8'd6, 0, PAUSE);
        a_step("pl_load9", 1, 8'd9, 1, 0, 0, 8'd9, 0, IDLE);

        // Priority and zero cases.
        a_step("pz_load",  1, 8'd3, 0, 0, 0, 8'd3, 0, IDLE);
        a_step("pz_start", 0, 8'd0, 1, 0, 0, 8'd3, 0, RUN);
        a_step("pz_2",     0, 8'd0, 0, 0, 0, 8'd2, 0, RUN);
        a_step("pz_1",     0, 8'd0, 0, 0, 0, 8'd1, 0, RUN);
        a_step("pz_all",   1, 8'd2, 1, 1, 0, 8'd2, 0, RUN);
        a_step("pz_start_ign", 0, 8'd0, 1, 0, 0, 8'd1, 0, RUN);
        a_step("pz_load0", 1, 8'd0, 0, 0, 0, 8'd0, 0, IDLE);
        a_step("pz_stop_idle", 0, 8'd0, 0, 1, 0, 8'd0, 0, IDLE);
        a_step("pz_start0",0, 8'd0, 1, 0, 0, 8'd0, 0, IDLE);

        // Full-range period on the narrow instance with auto-reload.
        a_load = 0; a_start = 0; a_stop = 0; a_ar = 0;
        b_step("w2_load",  1, 2'd3, 0, 0, 1, 8'd3, 0, IDLE);
        b_step("w2_start", 0, 2'd0, 1, 0, 1, 8'd3, 0, RUN);
        tc_seen = 0;
        for (int i = 1; i <= 9; i++) begin
            b_step($sformatf("w2_%0d", i), 0, 2'd0, 0, 0, 1,
                   (i % 3 == 0) ? 8'd3 : 8'(3 - (i % 3)), (i % 3 == 0), RUN);
            if (b_tc) tc_seen++;
        end
        chk("w2", "tc_pulses", 8'(tc_seen), 8'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/m_down_counter_timer.md
Name: m_down_counter_timer

Overview:
- Loadable down-counter with a terminal-count (TC) pulse. It complements the team's free-running up-counter.
- Software or an FSM loads a period, starts it, and gets a one-cycle w_tc pulse when the count reaches zero.
- Optional auto-reload turns it into a periodic tick generator.
- Sits beside the up-counter in timing/sequencing logic; single clock domain.

Parameters:
- WIDTH, 8, bit width of count and load value (>= 2).

Ports:
- w_clock  input  1  rising-edge clock.
- w_reset  input  1  asynchronous, active-high reset.
- w_load  input  1  load w_load_value into count and reload register this cycle.
- w_load_value  input  WIDTH  period value for w_load.
- w_start  input  1  begin/resume counting.
- w_stop  input  1  pause counting.
- w_auto_reload  input  1  on reaching zero, reload the period and keep running.
- w_count  output  WIDTH  current count (registered).
- w_tc  output  1  one-cycle pulse, registered, asserted in the cycle w_count becomes 0 or reloads.
- w_busy  output  1  high while in RUN.
- w_state  output  2  current FSM state (debug).

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high; clock port w_clock, reset port w_reset.
- Reset (async, any time including mid-count):
  - count=0, reload register=0, w_tc=0, state=IDLE, w_busy=0.
  - Takes effect immediately, not at the next edge.
- Input priority each edge: w_load > w_stop > w_start.
- All outputs are registered. w_tc defaults to 0 every cycle unless set below.
- IDLE (count holds):
  - w_load: count<=value, reload<=value, stay IDLE.
  - w_start with count!=0 -> RUN.
  - w_start with count==0 -> stays IDLE, no w_tc.
- RUN (count decrements by 1 per edge):
  - count>1: count<=count-1.
  - count==1, reaching zero: w_tc<=1 on that edge.
    - If w_auto_reload=1 and reload!=0: count<=reload, stay RUN.
    - Otherwise: count<=0, go IDLE.
  - w_stop: count holds, go PAUSE, no decrement that edge.
  - w_load: count<=value, reload<=value, no w_tc, no decrement.
    - Stays RUN if value!=0; value==0 -> IDLE.
  - w_start while in RUN: ignored.
- PAUSE (count holds):
  - w_start -> RUN; decrementing resumes on the following edge.
  - w_load: count<=value, reload<=value, go IDLE.
  - w_stop: stays PAUSE.
- Latency:
  - Load period N, start at edge k: RUN from edge k.
  - w_tc high for the cycle after edge k+N, i.e. N edges after entering RUN.
  - Auto-reload N: w_tc period is exactly N cycles.
- Arithmetic: count never underflows because the decrement stops at zero. Width is WIDTH throughout; max period is 2^WIDTH-1.
- Simultaneous w_load+w_stop+w_start: load wins; the others are ignored that cycle.
- w_auto_reload is sampled at the zero-reaching edge only.
- w_busy = (state==RUN), combinational from the state register.
- State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2. 2'd3 is illegal and recovers to IDLE on the next edge.

Decomposition:
- Shared package/include holds the state localparams (S_IDLE, S_RUN, S_PAUSE) and a default WIDTH. The existing up-counter and future timers reuse them.
- No sub-module: one state register, one count register, one reload register, and next-state logic fit in a single module.

Test Plan:
- Reset mid-run:
  - Load 5, start, assert w_reset after 2 cycles.
  - Immediately (asynchronously, before the next clock edge): w_count=0, w_state=0, w_tc=0, w_busy=0.
- One-shot:
  - Load 3, start.
  - w_count 3,2,1,0 on successive edges.
  - w_tc=1 exactly in the cycle w_count=0.
  - Then IDLE, w_busy=0, count stays 0.
- Auto-reload:
  - Load 4, w_auto_reload=1, start, run 20 cycles.
  - w_tc pulses every 4 cycles (5 pulses).
  - w_count sequence 4,3,2,1,4,3,... never shows 0.
- Pause/resume:
  - Load 6, start, stop at count 4, hold 3 cycles: count stays 4, w_state=2.
  - Start again: counts 3,2,1,0, w_tc once.
- Priority and zero cases:
  - Start with count 0 -> no RUN, no w_tc.
  - Load 2 with start and stop all high in RUN -> count=2, state RUN, no w_tc.
  - Load 0 in RUN -> IDLE, w_tc=0.
- Wrap width:
  - WIDTH=2, load 3, auto-reload: w_count 3,2,1,3,..., w_tc every 3 cycles.
